// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode/funct and datapath select encodings for the MIPS multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_NONE} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps ALUOp and Funct to the ALU control code; ALUOP_NONE yields 000
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_ok
);
  assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  assign alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                       alu_op == ALUOP_SUB ? ALU_SUB :
                       alu_op == ALUOP_NONE ? 3'b000 :
                       funct == FN_ADD ? ALU_ADD :
                       funct == FN_SUB ? ALU_SUB :
                       funct == FN_AND ? ALU_AND :
                       funct == FN_OR  ? ALU_OR  :
                       funct == FN_SLT ? ALU_SLT : 3'b000;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory handshake and wait watchdog.
// Define MIPS_MC_CTRL_BNE_EN to add bne support through the BRANCH state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       IllegalOp,
  output logic       MemTimeout,
  output logic [3:0] State
);
  state_t state, state_nx, op_nx;
  alu_op_t alu_op;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0] alu_dec;
  logic funct_ok, mem_state, done, expire, branch_take;
  assign mem_state = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign done = mem_state && MemReady;
  assign expire = TIMEOUT_CYCLES != 0 && mem_state && !MemReady && wait_cnt == CNT_W'(TIMEOUT_CYCLES);
  assign alu_op = state inside {S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX} ? ALUOP_ADD :
                  state == S_EXEC ? ALUOP_FUNCT :
                  state == S_BRANCH ? ALUOP_SUB : ALUOP_NONE;
  mips_alu_decoder u_alu_dec (
    .alu_op(alu_op),
    .funct(Funct),
    .alu_control(alu_dec),
    .funct_ok(funct_ok)
  );
`ifdef MIPS_MC_CTRL_BNE_EN
  logic is_bne;
  assign branch_take = is_bne ? !Zero : Zero;
  always_ff @(posedge clk)
    if (reset) is_bne <= 1'b0;
    else if (state == S_DECODE) is_bne <= Opcode == OP_BNE;
`else
  assign branch_take = Zero;
`endif
  always_comb begin
    op_nx = S_FETCH;
    case (Opcode)
      OP_LW, OP_SW: op_nx = S_MEMADR;
      OP_RTYPE:     op_nx = S_EXEC;
      OP_BEQ:       op_nx = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
      OP_BNE:       op_nx = S_BRANCH;
`endif
      OP_ADDI:      op_nx = S_ADDIEX;
      OP_J:         op_nx = S_JUMP;
      default:      op_nx = S_FETCH;
    endcase
  end
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = done ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = op_nx;
      S_MEMADR: state_nx = Opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nx = done ? S_MEMWB : expire ? S_FETCH : S_MEMRD;
      S_MEMWR:  state_nx = done || expire ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nx = funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_nx = S_ADDIWB;
      default:  state_nx = S_FETCH;
    endcase
  end
  // wait counter restarts whenever the access completes, times out or the state is left
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= mem_state && !MemReady && !expire ? wait_cnt + CNT_W'(1) : '0;
    end
  always_comb begin
    MemReq = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    PCEn = 1'b0;
    PCSrc = PC_ALU;
    AluSrcA = 1'b0;
    AluSrcB = SRCB_REG;
    AluControl = 3'b000;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    IllegalOp = 1'b0;
    MemTimeout = 1'b0;
    State = 4'd0;
    if (!reset) begin
      case (state)
        S_FETCH:  begin MemReq = 1'b1; AluSrcB = SRCB_FOUR; IRWrite = MemReady; PCEn = MemReady; end
        S_DECODE: begin AluSrcB = SRCB_IMMSH; IllegalOp = op_nx == S_FETCH; end
        S_MEMADR: begin AluSrcA = 1'b1; AluSrcB = SRCB_IMM; end
        S_MEMRD:  begin MemReq = 1'b1; IorD = 1'b1; end
        S_MEMWB:  begin MemtoReg = 1'b1; RegWrite = 1'b1; end
        S_MEMWR:  begin MemReq = 1'b1; MemWrite = 1'b1; IorD = 1'b1; end
        S_EXEC:   begin AluSrcA = 1'b1; IllegalOp = !funct_ok; end
        S_ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; end
        S_BRANCH: begin AluSrcA = 1'b1; PCSrc = PC_ALUOUT; PCEn = branch_take; end
        S_ADDIEX: begin AluSrcA = 1'b1; AluSrcB = SRCB_IMM; end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP:   begin PCSrc = PC_JUMP; PCEn = 1'b1; end
        default:  ;
      endcase
      AluControl = alu_dec;
      MemTimeout = expire;
      State = state;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table vectors, randomized instruction streams against a per-instruction cycle-script model, watchdog and reset corners
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic req, wr, iord, irw, pcen;
    logic [1:0] pcsrc;
    logic asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic rdst, m2r, rw, ill, tmo;
    logic [3:0] st;
  } out_t;
  typedef struct {
    logic [5:0] op, fn;
    logic z, mr, rst, wd;
    out_t e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, Zero = 1'b0, MemReady = 1'b0;
  logic [5:0] Opcode = '0, Funct = '0;
  logic a_req, a_wr, a_iord, a_irw, a_pcen, a_asa, a_rdst, a_m2r, a_rw, a_ill, a_tmo;
  logic b_req, b_wr, b_iord, b_irw, b_pcen, b_asa, b_rdst, b_m2r, b_rw, b_ill, b_tmo;
  logic [1:0] a_pcsrc, a_asb, b_pcsrc, b_asb;
  logic [2:0] a_alu, b_alu;
  logic [3:0] a_st, b_st;
  out_t got, got_wd;
  vec_t tbl[$], q[$];
  int nvec = 0, nerr = 0;
  logic bne_en;
  always #5 clk = ~clk;
  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(a_req), .MemWrite(a_wr), .IorD(a_iord), .IRWrite(a_irw), .PCEn(a_pcen), .PCSrc(a_pcsrc),
    .AluSrcA(a_asa), .AluSrcB(a_asb), .AluControl(a_alu), .RegDst(a_rdst), .MemtoReg(a_m2r),
    .RegWrite(a_rw), .IllegalOp(a_ill), .MemTimeout(a_tmo), .State(a_st)
  );
  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) wd (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .MemReq(b_req), .MemWrite(b_wr), .IorD(b_iord), .IRWrite(b_irw), .PCEn(b_pcen), .PCSrc(b_pcsrc),
    .AluSrcA(b_asa), .AluSrcB(b_asb), .AluControl(b_alu), .RegDst(b_rdst), .MemtoReg(b_m2r),
    .RegWrite(b_rw), .IllegalOp(b_ill), .MemTimeout(b_tmo), .State(b_st)
  );
  assign got = {a_req, a_wr, a_iord, a_irw, a_pcen, a_pcsrc, a_asa, a_asb, a_alu, a_rdst, a_m2r, a_rw, a_ill, a_tmo, a_st};
  assign got_wd = {b_req, b_wr, b_iord, b_irw, b_pcen, b_pcsrc, b_asa, b_asb, b_alu, b_rdst, b_m2r, b_rw, b_ill, b_tmo, b_st};
  function automatic out_t mk(input logic [3:0] st, input logic req, wr, iord, irw, pcen,
                              input logic [1:0] pcsrc, input logic asa, input logic [1:0] asb,
                              input logic [2:0] alu, input logic rdst, m2r, rw, ill, tmo);
    return '{req, wr, iord, irw, pcen, pcsrc, asa, asb, alu, rdst, m2r, rw, ill, tmo, st};
  endfunction
  function automatic vec_t v(input logic [5:0] op, fn, input logic z, mr, rst, w, input out_t e);
    return '{op, fn, z, mr, rst, w, e};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic add(input logic [5:0] op, fn, input logic z, mr, input out_t e);
    q.push_back(v(op, fn, z, mr, 1'b0, 1'b0, e));
  endtask
  task automatic apply(input vec_t x);
    out_t g;
    @(negedge clk);
    reset = x.rst; Opcode = x.op; Funct = x.fn; Zero = x.z; MemReady = x.mr;
    #1;
    g = x.wd ? got_wd : got;
    nvec++;
    if (g !== x.e) begin
      nerr++;
      $display("FAIL %s vec %0d op=%b fn=%b z=%b mr=%b rst=%b: got %h required %h (state got %0d required %0d)",
               x.wd ? "watchdog" : "ctrl", nvec, x.op, x.fn, x.z, x.mr, x.rst, g, x.e, g.st, x.e.st);
    end
  endtask
  // expected cycle script of one instruction with wf fetch waits and wm data-access waits
  task automatic model_instr(input logic [5:0] op, fn, input logic z, input int wf, wm);
    logic legal, ok;
    logic [2:0] a;
    legal = op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02} || (bne_en && op == 6'h05);
    for (int i = 0; i < wf; i++) add(op, fn, z, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0));
    add(op, fn, z, 1'b1, mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0));
    add(op, fn, z, rb(), mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 3'b010, 0, 0, 0, !legal, 0));
    if (!legal) return;
    if (op == 6'h23 || op == 6'h2b) begin
      add(op, fn, z, rb(), mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 3'b010, 0, 0, 0, 0, 0));
      for (int i = 0; i <= wm; i++)
        add(op, fn, z, i == wm, op == 6'h23 ? mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)
                                            : mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
      if (op == 6'h23) add(op, fn, z, rb(), mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0));
    end else if (op == 6'h00) begin
      ok = 1'b1;
      case (fn)
        6'b100000: a = 3'b010;
        6'b100010: a = 3'b110;
        6'b100100: a = 3'b000;
        6'b100101: a = 3'b001;
        6'b101010: a = 3'b111;
        default: begin a = 3'b000; ok = 1'b0; end
      endcase
      add(op, fn, z, rb(), mk(6, 0, 0, 0, 0, 0, 0, 1, 0, a, 0, 0, 0, !ok, 0));
      if (ok) add(op, fn, z, rb(), mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0));
    end else if (op == 6'h04 || op == 6'h05) begin
      add(op, fn, z, rb(), mk(8, 0, 0, 0, 0, op == 6'h05 ? !z : z, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0));
    end else if (op == 6'h08) begin
      add(op, fn, z, rb(), mk(9, 0, 0, 0, 0, 0, 0, 1, 2, 3'b010, 0, 0, 0, 0, 0));
      add(op, fn, z, rb(), mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0));
    end else begin
      add(op, fn, z, rb(), mk(11, 0, 0, 0, 0, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    end
  endtask
  initial begin
    out_t fe, de, zero_o, fw;
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
`ifdef MIPS_MC_CTRL_BNE_EN
    bne_en = 1'b1;
`else
    bne_en = 1'b0;
`endif
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    zero_o = '0;
    fe = mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0);
    fw = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0);
    de = mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 3'b010, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tbl.push_back(v(6'h23, 0, 0, 1'(i), 1, 0, zero_o));
    tbl.push_back(v(6'h23, 0, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h23, 0, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h23, 0, 0, 1, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 3'b010, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h23, 0, 0, 1, 0, 0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h23, 0, 0, 1, 0, 0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0)));
    tbl.push_back(v(6'h04, 0, 1, 1, 0, 0, fe));
    tbl.push_back(v(6'h04, 0, 1, 1, 0, 0, de));
    tbl.push_back(v(6'h04, 0, 1, 1, 0, 0, mk(8, 0, 0, 0, 0, 1, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h04, 0, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h04, 0, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h04, 0, 0, 1, 0, 0, mk(8, 0, 0, 0, 0, 0, 1, 1, 0, 3'b110, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h00, 6'h2a, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h00, 6'h2a, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h00, 6'h2a, 0, 1, 0, 0, mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h00, 6'h2a, 0, 1, 0, 0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0)));
    tbl.push_back(v(6'h00, 6'h07, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h00, 6'h07, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h00, 6'h07, 0, 1, 0, 0, mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0)));
    tbl.push_back(v(6'h02, 0, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h02, 0, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h02, 0, 0, 1, 0, 0, mk(11, 0, 0, 0, 0, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h08, 0, 0, 1, 0, 0, fe));
    tbl.push_back(v(6'h08, 0, 0, 1, 0, 0, de));
    tbl.push_back(v(6'h08, 0, 0, 1, 0, 0, mk(9, 0, 0, 0, 0, 0, 0, 1, 2, 3'b010, 0, 0, 0, 0, 0)));
    tbl.push_back(v(6'h08, 0, 0, 1, 0, 0, mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0)));
    foreach (tbl[i]) apply(tbl[i]);
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      model_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    model_instr(6'h2b, 0, 0, 0, 5);
    model_instr(6'h05, 0, 0, 0, 0);
    model_instr(6'h05, 0, 1, 1, 0);
    add(6'h23, 0, 0, 1, fe);
    add(6'h23, 0, 0, 1, de);
    add(6'h23, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 3'b010, 0, 0, 0, 0, 0));
    add(6'h23, 0, 0, 0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    add(6'h23, 0, 0, 0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    q.push_back(v(6'h23, 0, 0, 1, 1, 0, zero_o));
    q.push_back(v(6'h23, 0, 0, 1, 1, 0, zero_o));
    model_instr(6'h08, 0, 0, 1, 0);
    q.push_back(v(6'h02, 0, 0, 0, 1, 1, zero_o));
    for (int i = 0; i < 5; i++) q.push_back(v(6'h02, 0, 0, 0, 0, 1, i == 4 ? mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1) : fw));
    for (int i = 0; i < 4; i++) q.push_back(v(6'h02, 0, 0, 0, 0, 1, fw));
    q.push_back(v(6'h02, 0, 0, 1, 0, 1, fe));
    q.push_back(v(6'h02, 0, 0, 0, 0, 1, de));
    q.push_back(v(6'h02, 0, 0, 0, 0, 1, mk(11, 0, 0, 0, 0, 1, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0)));
    foreach (q[i]) apply(q[i]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the MIPS datapath over several cycles per instruction. It sits beside the existing datapath, replacing the single-cycle combinational control path. It shares one unified instruction/data memory through a req/ready handshake, and drives all datapath mux selects and write strobes from its current state.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles for MemReady per access; 0 disables the watchdog
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  Instruction[31:26] from the instruction register
Funct  in  6  Instruction[5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request
MemWrite  out  1  write qualifier for MemReq
IorD  out  1  0 = PC addresses memory, 1 = AluOut addresses memory
IRWrite  out  1  load instruction register
PCEn  out  1  PC load enable
PCSrc  out  2  00 ALU result, 01 AluOut register, 10 jump target
AluSrcA  out  1  0 = PC, 1 = register A
AluSrcB  out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
AluControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data, 0 = AluOut
RegWrite  out  1  register file write strobe
IllegalOp  out  1  one-cycle pulse on an unsupported opcode
MemTimeout  out  1  one-cycle pulse on a watchdog expiry
State  out  4  current state encoding, for debug

Behaviour:
- Reset: while reset=1, every output is 0 and State=FETCH. The wait counter clears. Reset asserted in any state returns to FETCH at the next edge and aborts any pending access.
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXEC(6), ALUWB(7), BRANCH(8), ADDIEX(9), ADDIWB(10), JUMP(11).
- FETCH:
  - MemReq=1, IorD=0, AluSrcA=0, AluSrcB=01, add, PCSrc=00.
  - Holds until MemReady=1. In that cycle only, IRWrite=1 and PCEn=1, then go to DECODE.
- DECODE:
  - AluSrcA=0, AluSrcB=11, add (branch target into AluOut).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH with IllegalOp=1 for this cycle.
- MEMADR: AluSrcA=1, AluSrcB=10, add. Go to MEMRD if lw, MEMWR if sw.
- MEMRD: MemReq=1, IorD=1. Holds until MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
- EXEC:
  - AluSrcA=1, AluSrcB=00. AluControl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> FETCH with IllegalOp pulse.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, sub, PCSrc=01, PCEn=Zero, then FETCH.
- ADDIEX: AluSrcA=1, AluSrcB=10, add, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JUMP: PCSrc=10, PCEn=1, then FETCH.
- Signals not listed for a state are 0.
- Handshake:
  - MemReq stays high and all address/select outputs stay stable while waiting.
  - The access completes in the first cycle with MemReq & MemReady. MemReady=1 in the first cycle gives zero wait.
  - MemReady while MemReq=0 is ignored.
- Watchdog:
  - Counter increments each cycle in a memory state with MemReady=0, and clears on state exit.
  - When it reaches TIMEOUT_CYCLES: go to FETCH, pulse MemTimeout. PC and IR are not written and RegWrite stays 0.
  - MemReady=1 in the same cycle as expiry wins: normal completion, no timeout.
- Latency with zero memory wait: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.

Optional Feature:
MIPS_MC_CTRL_BNE_EN
- Defined: opcode 000101 (bne) in DECODE -> BRANCH. In BRANCH, PCEn = ~Zero for bne and Zero for beq. The controller registers a 1-bit branch-sense flag in DECODE.
- Undefined: 000101 is illegal (IllegalOp pulse, -> FETCH) and no flag register exists.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit);
  - opcode and funct constants;
  - AluControl, PCSrc and AluSrcB encodings.
- One natural sub-module, mips_alu_decoder: combinational Funct/ALUOp -> AluControl, shared with the single-cycle control path.
- The FSM, watchdog counter and output decode stay in mips_multicycle_ctrl.

Test Plan:
- Reset held 3 cycles, then released; Opcode=100011, MemReady always 1 -> States 0,1,2,3,4,0. IRWrite/PCEn only in FETCH, RegWrite=1 and MemtoReg=1 only in state 4.
- beq (000100) with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. Repeat with Zero=0 -> PCEn=0 throughout BRANCH.
- R-type with Funct=101010 -> AluControl=111 in EXEC, then RegWrite=1, RegDst=1 in ALUWB. Funct=000111 -> IllegalOp pulse, next state FETCH.
- sw with MemReady held low 5 cycles in MEMWR -> MemReq=MemWrite=IorD=1 stable for 6 cycles, completion on cycle 6, then FETCH.
- TIMEOUT_CYCLES=4, MemReady stuck 0 in FETCH -> MemTimeout pulse after 4 wait cycles, IRWrite/PCEn never asserted, re-enter FETCH. Reset asserted mid-MEMRD -> FETCH next edge, all outputs 0 during reset.
- Opcode 000101 with Zero=0 -> with MIPS_MC_CTRL_BNE_EN: BRANCH, PCEn=1. Without it: IllegalOp=1 in DECODE, then FETCH.
